// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types, row-drive reset pattern and key-frame helpers for the keypad scanner.
package keypad_pkg;
    typedef logic [3:0] key_code_t;
    typedef logic [15:0] key_frame_t;
    localparam logic [3:0] ROW_INIT = 4'b1110;
    function automatic logic popcount_is_one(input key_frame_t f);
        return f != '0 && (f & (f - 16'd1)) == '0;
    endfunction
    function automatic key_code_t frame_to_code(input key_frame_t f);
        key_code_t c;
        c = '0;
        for (int i = 15; i >= 0; i--)
            if (f[i]) c = key_code_t'(i);
        return c;
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: row drive, column sense and key event signals between scanner and its neighbours.
interface keypad_scanner_if;
    import keypad_pkg::*;
    logic [3:0] rowEnableOut;
    logic [3:0] colSenseIn;
    key_code_t keyCodeOut;
    logic keyValidOut;
    logic keyHeldOut;
    modport master(output rowEnableOut, keyCodeOut, keyValidOut, keyHeldOut, input colSenseIn);
    modport slave(input rowEnableOut, keyCodeOut, keyValidOut, keyHeldOut, output colSenseIn);
endinterface

// File: rtl/keypad_scanner_tick.sv
// scan_tick: free-running divider emitting a one-cycle tick every DWELL clocks.
module scan_tick #(
    parameter int DWELL = 10
) (
    input  logic clkIn,
    input  logic resetIn,
    output logic tick
);
    localparam int W = DWELL > 1 ? $clog2(DWELL) : 1;
    logic [W-1:0] cnt;
    always_comb tick = cnt == W'(DWELL - 1);
    always_ff @(posedge clkIn)
        if (resetIn) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 row-multiplexed keypad scan, frame debounce and single-press key events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 27000000,
    parameter int SCAN_RATE_HZ   = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic clkIn,
    input logic resetIn,
    keypad_scanner_if.master kp
);
    localparam int DWELL = CLK_FREQUENCY / SCAN_RATE_HZ;
    localparam int SW = $clog2(DEBOUNCE_SCANS);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);
    logic tick, frame_done, deb_update, new_press;
    logic [3:0] sync1, sync2;
    logic [1:0] row;
    key_frame_t frame, prev_frame, deb, new_frame;
    logic [SW-1:0] stable, stable_next;
    scan_tick #(.DWELL(DWELL)) u_tick (.clkIn(clkIn), .resetIn(resetIn), .tick(tick));
    always_comb begin
        new_frame = frame;
        new_frame[{row, 2'b00} +: 4] = ~sync2;
        frame_done = tick && row == 2'd3;
        stable_next = new_frame != prev_frame ? '0 : stable == STABLE_MAX ? stable : stable + 1'b1;
        deb_update = frame_done && stable_next == STABLE_MAX;
        new_press = deb_update && deb == '0 && popcount_is_one(new_frame);
    end
    // Columns idle high through pull-ups, so the synchronizer resets to "nothing pressed".
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            sync1 <= '1;
            sync2 <= '1;
            row <= '0;
            frame <= '0;
            prev_frame <= '0;
            deb <= '0;
            stable <= '0;
            kp.rowEnableOut <= ROW_INIT;
            kp.keyCodeOut <= '0;
            kp.keyValidOut <= 1'b0;
            kp.keyHeldOut <= 1'b0;
        end else begin
            sync1 <= kp.colSenseIn;
            sync2 <= sync1;
            kp.keyValidOut <= new_press;
            kp.keyHeldOut <= deb_update ? new_frame != '0 : deb != '0;
            if (tick) begin
                frame <= new_frame;
                row <= row + 1'b1;
                kp.rowEnableOut <= {kp.rowEnableOut[2:0], kp.rowEnableOut[3]};
            end
            if (frame_done) begin
                stable <= stable_next;
                prev_frame <= new_frame;
            end
            if (deb_update) deb <= new_frame;
            if (new_press) kp.keyCodeOut <= frame_to_code(new_frame);
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving the scanner, windowed debounce reference, table and random checks.
module tb_keypad_scanner;
    import keypad_pkg::*;
    localparam int DWELL = 10;
    localparam int DEB = 3;
    typedef struct {
        logic [15:0] keys;
        int cyc;
        int pulses;
        logic [3:0] code;
        logic held;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] keys = '0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;
    bit started = 0;
    keypad_scanner_if kp();
    keypad_scanner #(.CLK_FREQUENCY(1000), .SCAN_RATE_HZ(100), .DEBOUNCE_SCANS(DEB)) dut (
        .clkIn(clk), .resetIn(rst), .kp(kp));
    always #5 clk = ~clk;
    function automatic logic [3:0] cols(input logic [3:0] re, input logic [15:0] k);
        for (int r = 0; r < 4; r++)
            if (re == ~(4'b0001 << r)) return ~k[r*4 +: 4];
        return 4'hF;
    endfunction
    assign kp.colSenseIn = cols(kp.rowEnableOut, keys);
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    // Reference: a key reaches a frame two clocks after it is seen; the debounced state
    // follows whenever the last DEB frames (reset counts as an all-zero frame) agree.
    int n;
    logic [15:0] kh[$];
    key_frame_t m_frame, m_deb;
    key_frame_t frames[$];
    logic [3:0] m_code, m_rowen;
    logic m_valid, m_held;
    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            kh = {};
            m_frame = '0;
            m_deb = '0;
            frames = {16'h0};
            m_code = '0;
            m_valid = 1'b0;
            m_held = 1'b0;
        end else begin
            m_valid = 1'b0;
            kh.push_back(keys);
            if (kh.size() > 3) void'(kh.pop_front());
            if (n % DWELL == DWELL - 1) begin
                int r;
                r = (n / DWELL) % 4;
                m_frame[r*4 +: 4] = kh.size() == 3 ? kh[0][r*4 +: 4] : 4'h0;
                if (r == 3) begin
                    bit same;
                    frames.push_back(m_frame);
                    if (frames.size() > DEB) void'(frames.pop_front());
                    same = frames.size() == DEB;
                    foreach (frames[i]) if (frames[i] != m_frame) same = 0;
                    if (same) begin
                        if (m_deb == '0 && $countones(m_frame) == 1) begin
                            for (int b = 15; b >= 0; b--) if (m_frame[b]) m_code = 4'(b);
                            m_valid = 1'b1;
                        end
                        m_deb = m_frame;
                    end
                end
            end
            n++;
            m_held = m_deb != '0;
        end
        m_rowen = ~(4'b0001 << ((n / DWELL) % 4));
        started = 1;
    end
    always @(negedge clk) if (started) begin
        check("row", 16'(kp.rowEnableOut), 16'(m_rowen));
        check("valid", 16'(kp.keyValidOut), 16'(m_valid));
        check("code", 16'(kp.keyCodeOut), 16'(m_code));
        check("held", 16'(kp.keyHeldOut), 16'(m_held));
        if (kp.keyValidOut === 1'b1) pulses++;
    end
    task automatic run(input int c);
        repeat (c) @(negedge clk);
    endtask
    vec_t tbl[9];
    initial begin
        tbl[0] = '{16'h0000, 200, 0, 4'd0, 1'b0};
        tbl[1] = '{16'h0200, 200, 1, 4'd9, 1'b1};
        tbl[2] = '{16'h0000, 200, 0, 4'd9, 1'b0};
        tbl[3] = '{16'h8001, 200, 0, 4'd9, 1'b1};
        tbl[4] = '{16'h0001, 200, 0, 4'd9, 1'b1};
        tbl[5] = '{16'h0000, 200, 0, 4'd9, 1'b0};
        tbl[6] = '{16'h8000, 200, 1, 4'd15, 1'b1};
        tbl[7] = '{16'h0000, 200, 0, 4'd15, 1'b0};
        tbl[8] = '{16'h0020, 200, 1, 4'd5, 1'b1};
        run(3);
        check("reset_row", 16'(kp.rowEnableOut), 16'hE);
        check("reset_code", 16'(kp.keyCodeOut), 16'h0);
        check("reset_valid", 16'(kp.keyValidOut), 16'h0);
        check("reset_held", 16'(kp.keyHeldOut), 16'h0);
        rst = 1'b0;
        foreach (tbl[i]) begin
            pulses = 0;
            keys = tbl[i].keys;
            run(tbl[i].cyc);
            check($sformatf("tbl%0d_pulses", i), 16'(pulses), 16'(tbl[i].pulses));
            check($sformatf("tbl%0d_code", i), 16'(kp.keyCodeOut), 16'(tbl[i].code));
            check($sformatf("tbl%0d_held", i), 16'(kp.keyHeldOut), 16'(tbl[i].held));
        end
        keys = '0;
        run(200);
        pulses = 0;
        for (int t = 0; t < 300; t++) begin
            keys = (t / 35) % 2 == 0 ? 16'h0200 : 16'h0000;
            @(negedge clk);
        end
        check("bounce_pulses", 16'(pulses), 16'd0);
        keys = 16'h0200;
        run(200);
        check("bounce_hold_pulses", 16'(pulses), 16'd1);
        check("bounce_hold_code", 16'(kp.keyCodeOut), 16'd9);
        keys = '0;
        run(200);
        check("bounce_release_held", 16'(kp.keyHeldOut), 16'd0);
        pulses = 0;
        keys = 16'h0020;
        run(215);
        check("pre_reset_pulses", 16'(pulses), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_row", 16'(kp.rowEnableOut), 16'hE);
        check("midreset_code", 16'(kp.keyCodeOut), 16'h0);
        check("midreset_valid", 16'(kp.keyValidOut), 16'h0);
        check("midreset_held", 16'(kp.keyHeldOut), 16'h0);
        rst = 1'b0;
        pulses = 0;
        run(200);
        check("post_reset_pulses", 16'(pulses), 16'd1);
        check("post_reset_code", 16'(kp.keyCodeOut), 16'd5);
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            keys = sel < 4 ? 16'h0 : sel < 8 ? 16'h1 << $urandom_range(0, 15) : 16'($urandom);
            run(int'($urandom_range(20, 160)));
        end
        keys = '0;
        run(200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
